jam_cost_server: RTL
====================

# jam_cost_server

Host-side counterpart of the JAM job-assignment engine. Accepts a 64-entry worker×job cost table over a valid/ready load stream and holds JAM in reset while loading. Releases JAM, answers its W/J cost lookups, then captures MinCost/MatchCount on Valid and returns them over a valid/ready result port, with a cycle-count timeout guard.

## Interface
- RST_CYCLES, default 2: cycles `jam_rst` is held high after the table is full, before JAM is released.
- TIMEOUT, default 1000000: maximum RUN cycles to wait for `Valid`; counter is 20 bits.
- CLK  input  1  single clock, all logic on posedge.
- RST  input  1  one clock; reset is synchronous and active-low.
- load_valid  input  1  load word present.
- load_ready  output  1  combinational, high iff state is LOAD.
- load_data  input  7  cost word, row-major (index = W*8+J).
- jam_rst  output  1  registered, active-high reset driven to JAM.
- W  input  3  JAM worker address.
- J  input  3  JAM job address.
- Cost  output  7  combinational table read for JAM.
- Valid  input  1  JAM done flag.
- MinCost  input  10  JAM result.
- MatchCount  input  4  JAM result.
- res_valid  output  1  result available.
- res_ready  input  1  result consumer accepts.
- res_min_cost  output  10  captured MinCost.
- res_match_count  output  4  captured MatchCount.
- res_timeout  output  1  result produced by timeout, not by Valid.

## Operation
- Storage: 64×7-bit table, write address = 6-bit load counter, read address = {W,J}.
- States: LOAD → START → RUN → DONE → LOAD.
- LOAD:
  - `load_ready`=1; each `load_valid` cycle writes `load_data` at the counter and increments it.
  - When the 64th word is accepted, the counter wraps to 0 and the next state is START.
  - `jam_rst`=1.
- START:
  - `jam_rst`=1 for exactly RST_CYCLES cycles.
  - Then RUN, with `jam_rst`=0 on the first RUN cycle and the cycle counter cleared.
- RUN:
  - `Cost` = table[{W,J}].
  - Counter increments each cycle.
  - On the first posedge with `Valid`=1: capture `MinCost` and `MatchCount`, `res_timeout`←0, `res_valid`←1, go to DONE.
  - Otherwise, if the counter reaches TIMEOUT-1: `res_min_cost`←1023, `res_match_count`←0, `res_timeout`←1, `res_valid`←1, go to DONE.
  - `Valid` wins if it coincides with the timeout cycle.
- DONE:
  - `jam_rst`←1 (JAM frozen).
  - Result registers are stable while `res_valid`=1.
  - On `res_valid`&&`res_ready`: `res_valid`←0, go to LOAD, load counter=0.
- `Cost` = 0 in LOAD. In START and DONE it still reads table[{W,J}].
- `load_valid` outside LOAD is ignored; no write occurs.

## Timing
- Reset (RST=0 sampled at posedge):
  - state LOAD, load counter 0, `jam_rst`=1, `res_valid`=0.
  - `res_min_cost`=0, `res_match_count`=0, `res_timeout`=0, cycle counter 0.
  - Table contents are not cleared.
- Reset mid-operation in any state aborts to the values above; a partial load restarts at index 0.
- Load throughput: one word per cycle; 64 cycles minimum with continuous `load_valid`.
- Last-word to `jam_rst` fall: RST_CYCLES+1 posedges.
- Valid to `res_valid`: 1 cycle (registered).
- `res_valid` stays high until accepted; there is no retraction.
- The result handshake and return to LOAD occur on the same posedge; `load_ready` rises the following cycle.
- `Cost` is combinational from W/J with no latency. JAM samples it at negedge, so the read path must settle within half a cycle.

## Test plan
- Load table[i]=i%64 → after load, drive W=3,J=5 in RUN → `Cost`=29; W=7,J=7 → 63; `Cost`=0 while in LOAD.
- Load with `load_valid` toggling every other cycle → exactly 64 writes; `jam_rst` falls RST_CYCLES+1 cycles after the 64th accept; `load_ready`=0 from START onward.
- In RUN, pulse `Valid`=1 with MinCost=10'd284, MatchCount=4'd3 → next cycle `res_valid`=1, 284/3, `res_timeout`=0, `jam_rst`=1.
- Hold `res_ready`=0 for 10 cycles → result stable and `res_valid` held; assert `res_ready` → `res_valid`=0 and state LOAD, `load_ready`=1 the next cycle.
- TIMEOUT=50, never assert `Valid` → `res_valid` rises on RUN cycle 50 with 1023/0/`res_timeout`=1; `Valid` asserted on the same edge → normal capture with `res_timeout`=0.
- Assert RST=0 after 30 loaded words → `load_ready`=1 with counter 0; a fresh 64-word load completes normally.

Source files
------------

// File: rtl/jam_cost_server.sv
// jam_cost_server: host-side companion for the JAM assignment engine.
// Loads a 64-entry worker x job cost table, holds JAM in reset while
// loading, then releases it, serves its cost lookups and returns the
// result (or a timeout marker) over a valid/ready result port.
module jam_cost_server #(
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 1000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [6:0] load_data,
  output logic       jam_rst,
  input  logic [2:0] W,
  input  logic [2:0] J,
  output logic [6:0] Cost,
  input  logic       Valid,
  input  logic [9:0] MinCost,
  input  logic [3:0] MatchCount,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [9:0] res_min_cost,
  output logic [3:0] res_match_count,
  output logic       res_timeout
);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Last START count before release, and last RUN count before giving up.
  localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);
  localparam logic [19:0] TO_LAST  = 20'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [5:0]  load_cnt_q, load_cnt_d;
  logic [15:0] rst_cnt_q, rst_cnt_d;
  logic [19:0] cyc_cnt_q, cyc_cnt_d;
  logic        jam_rst_q, jam_rst_d;
  logic        res_valid_q, res_valid_d;
  logic [9:0]  res_min_cost_q, res_min_cost_d;
  logic [3:0]  res_match_count_q, res_match_count_d;
  logic        res_timeout_q, res_timeout_d;

  // Cost table; JAM reads it asynchronously, so no read register here.
  logic [6:0]  cost_mem_q [0:63];

  logic        load_fire;
  logic        last_word;
  logic        start_last;
  logic        timeout_hit;
  logic        res_fire;

  assign load_fire   = (state_q == S_LOAD) && load_valid;
  assign last_word   = load_fire && (load_cnt_q == 6'd63);
  assign start_last  = (state_q == S_START) && (rst_cnt_q == RST_LAST);
  assign timeout_hit = (cyc_cnt_q == TO_LAST);
  assign res_fire    = (state_q == S_DONE) && res_valid_q && res_ready;

  // State register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: LOAD -> START -> RUN -> DONE -> LOAD.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  if (last_word) state_d = S_START;
      S_START: if (start_last) state_d = S_RUN;
      S_RUN:   if (Valid || timeout_hit) state_d = S_DONE;
      S_DONE:  if (res_fire) state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  // Moore outputs: load handshake and the JAM cost read port.
  always_comb begin
    load_ready = (state_q == S_LOAD);
    Cost       = 7'd0;
    if (state_q != S_LOAD) begin
      Cost = cost_mem_q[{W, J}];
    end
  end

  // Counter and result next-state values.
  always_comb begin
    load_cnt_d        = load_cnt_q;
    rst_cnt_d         = 16'd0;
    cyc_cnt_d         = 20'd0;
    res_valid_d       = res_valid_q;
    res_min_cost_d    = res_min_cost_q;
    res_match_count_d = res_match_count_q;
    res_timeout_d     = res_timeout_q;

    // Load index wraps naturally from 63 to 0 on the last word.
    if (load_fire) begin
      load_cnt_d = load_cnt_q + 6'd1;
    end

    // START counter is zero on entry because it idles at zero elsewhere.
    if (state_q == S_START) begin
      rst_cnt_d = rst_cnt_q + 16'd1;
    end

    if (state_q == S_RUN) begin
      cyc_cnt_d = cyc_cnt_q + 20'd1;
      // A genuine result takes priority over a simultaneous timeout.
      if (Valid) begin
        res_valid_d       = 1'b1;
        res_min_cost_d    = MinCost;
        res_match_count_d = MatchCount;
        res_timeout_d     = 1'b0;
      end else if (timeout_hit) begin
        res_valid_d       = 1'b1;
        res_min_cost_d    = 10'd1023;
        res_match_count_d = 4'd0;
        res_timeout_d     = 1'b1;
      end
    end

    if (res_fire) begin
      res_valid_d = 1'b0;
      load_cnt_d  = 6'd0;
    end
  end

  // JAM runs only while the FSM sits in RUN; registered so it is glitch-free.
  always_comb begin
    jam_rst_d = (state_d != S_RUN);
  end

  // Datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      load_cnt_q        <= 6'd0;
      rst_cnt_q         <= 16'd0;
      cyc_cnt_q         <= 20'd0;
      jam_rst_q         <= 1'b1;
      res_valid_q       <= 1'b0;
      res_min_cost_q    <= 10'd0;
      res_match_count_q <= 4'd0;
      res_timeout_q     <= 1'b0;
    end else begin
      load_cnt_q        <= load_cnt_d;
      rst_cnt_q         <= rst_cnt_d;
      cyc_cnt_q         <= cyc_cnt_d;
      jam_rst_q         <= jam_rst_d;
      res_valid_q       <= res_valid_d;
      res_min_cost_q    <= res_min_cost_d;
      res_match_count_q <= res_match_count_d;
      res_timeout_q     <= res_timeout_d;
    end
  end

  // Table write port; contents survive reset, only writes are blocked.
  always_ff @(posedge CLK) begin
    if (RST && load_fire) begin
      cost_mem_q[load_cnt_q] <= load_data;
    end
  end

  assign jam_rst         = jam_rst_q;
  assign res_valid       = res_valid_q;
  assign res_min_cost    = res_min_cost_q;
  assign res_match_count = res_match_count_q;
  assign res_timeout     = res_timeout_q;

endmodule
